// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: arbitrates the CPU memory bus between the CPU core and an
// OAM DMA engine. A CPU write to DMA_REG_ADDR stalls the CPU and copies the
// 256 bytes of page {data, 8'h00} to OAM_DATA_ADDR, then hands the bus back.
//
// Bus handshake: there is no back-pressure on this bus. A strobe
// (mem_read_en / mem_write_en) is valid for exactly the cycle it is high.
// Read data is valid READ_LAT cycles after the read-strobe cycle, and the
// engine samples it in that cycle. cpu_stall is the only "not ready" signal
// toward the CPU; while it is high the CPU holds state and its bus requests
// are ignored.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          READ_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  output logic        cpu_stall,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        mem_write_en,
  output logic        mem_read_en,
  input  logic [7:0]  mem_data_in,
  output logic        dma_busy,
  output logic        dma_done,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_RD    = 3'd2,
    S_WAIT  = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Countdown loaded in RD so WAIT lasts exactly READ_LAT cycles.
  localparam logic [2:0] WAIT_LOAD = 3'(READ_LAT - 1);

  state_t      state, state_n;
  logic [7:0]  page, page_n;
  logic [7:0]  idx, idx_n;
  logic [2:0]  wait_cnt, wait_n;
  logic [7:0]  latch, latch_n;

  // Registered DMA-side bus; only visible on mem_* outside IDLE.
  logic [15:0] dma_addr, dma_addr_n;
  logic [7:0]  dma_data, dma_data_n;
  logic        dma_we, dma_we_n;
  logic        dma_re, dma_re_n;

  logic        trigger;

  assign trigger   = cpu_write_en && (cpu_addr == DMA_REG_ADDR);
  assign fsm_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state logic; retriggers outside IDLE are simply not looked at.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (trigger) state_n = S_ALIGN;
      S_ALIGN: state_n = S_RD;
      S_RD:    state_n = S_WAIT;
      S_WAIT:  if (wait_cnt == 3'd0) state_n = S_WR;
      S_WR:    state_n = (idx == 8'hFF) ? S_DONE : S_RD;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of the transfer registers (page, index, wait counter, data latch).
  always_comb begin
    page_n  = page;
    idx_n   = idx;
    wait_n  = wait_cnt;
    latch_n = latch;
    case (state)
      S_IDLE: begin
        if (trigger) begin
          page_n = cpu_data_out;
          idx_n  = 8'h00;
        end
      end
      S_RD:   wait_n = WAIT_LOAD;
      S_WAIT: begin
        if (wait_cnt == 3'd0) latch_n = mem_data_in;
        else                  wait_n  = wait_cnt - 3'd1;
      end
      // idx is only 8 bits, so the source never carries into the page byte.
      S_WR:   if (idx != 8'hFF) idx_n = idx + 8'd1;
      default: ;
    endcase
  end

  // DMA bus values for the state being entered, so they are registered
  // and appear on the bus in that state's cycle.
  always_comb begin
    dma_addr_n = 16'h0000;
    dma_data_n = 8'h00;
    dma_we_n   = 1'b0;
    dma_re_n   = 1'b0;
    case (state_n)
      S_RD: begin
        dma_addr_n = {page_n, idx_n};
        dma_re_n   = 1'b1;
      end
      S_WR: begin
        dma_addr_n = OAM_DATA_ADDR;
        dma_data_n = latch_n;
        dma_we_n   = 1'b1;
      end
      default: ;
    endcase
  end

  // Transfer registers and registered DMA bus; reset abandons any transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      page     <= 8'h00;
      idx      <= 8'h00;
      wait_cnt <= 3'd0;
      latch    <= 8'h00;
      dma_addr <= 16'h0000;
      dma_data <= 8'h00;
      dma_we   <= 1'b0;
      dma_re   <= 1'b0;
    end else begin
      page     <= page_n;
      idx      <= idx_n;
      wait_cnt <= wait_n;
      latch    <= latch_n;
      dma_addr <= dma_addr_n;
      dma_data <= dma_data_n;
      dma_we   <= dma_we_n;
      dma_re   <= dma_re_n;
    end
  end

  // Output logic: CPU passes straight through in IDLE, DMA owns the bus otherwise.
  always_comb begin
    cpu_stall    = (state != S_IDLE);
    dma_busy     = (state != S_IDLE) && (state != S_DONE);
    dma_done     = (state == S_DONE);
    mem_addr     = dma_addr;
    mem_data_out = dma_data;
    mem_write_en = dma_we;
    mem_read_en  = dma_re;
    if (state == S_IDLE) begin
      mem_addr     = cpu_addr;
      mem_data_out = cpu_data_out;
      mem_write_en = cpu_write_en;
      mem_read_en  = cpu_read_en;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed testbench for oam_dma_ctrl: a READ_LAT=2 instance carries most of
// the scenarios, a READ_LAT=1 instance checks the shorter per-byte timing.
module tb_oam_dma_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT (READ_LAT = 2) ----------------
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_write_en, cpu_read_en;
  logic        cpu_stall, mem_write_en, mem_read_en, dma_busy, dma_done;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out, mem_data_in;
  logic [2:0]  fsm_state;

  oam_dma_ctrl #(.READ_LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en),
    .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_data_in(mem_data_in), .dma_busy(dma_busy), .dma_done(dma_done),
    .fsm_state(fsm_state)
  );

  // ---------------- DUT (READ_LAT = 1) ----------------
  logic [15:0] l1_cpu_addr;
  logic [7:0]  l1_cpu_data_out;
  logic        l1_cpu_write_en, l1_cpu_read_en;
  logic        l1_cpu_stall, l1_mem_write_en, l1_mem_read_en, l1_dma_busy, l1_dma_done;
  logic [15:0] l1_mem_addr;
  logic [7:0]  l1_mem_data_out, l1_mem_data_in;
  logic [2:0]  l1_fsm_state;

  oam_dma_ctrl #(.READ_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .cpu_addr(l1_cpu_addr), .cpu_data_out(l1_cpu_data_out),
    .cpu_write_en(l1_cpu_write_en), .cpu_read_en(l1_cpu_read_en),
    .cpu_stall(l1_cpu_stall), .mem_addr(l1_mem_addr), .mem_data_out(l1_mem_data_out),
    .mem_write_en(l1_mem_write_en), .mem_read_en(l1_mem_read_en),
    .mem_data_in(l1_mem_data_in), .dma_busy(l1_dma_busy), .dma_done(l1_dma_done),
    .fsm_state(l1_fsm_state)
  );

  // ---------------- memory model ----------------
  // Data is driven only in the cycle READ_LAT after the read strobe; any
  // other cycle shows 8'hEE so a mistimed sample is visible.
  logic [7:0]  ram [0:65535];
  logic [16:0] p0_a = '0, p0_b = '0, p1_a = '0;

  always @(posedge clk) begin
    p0_a <= {mem_read_en, mem_addr};
    p0_b <= p0_a;
    p1_a <= {l1_mem_read_en, l1_mem_addr};
  end

  assign mem_data_in    = p0_b[16] ? ram[p0_b[15:0]] : 8'hEE;
  assign l1_mem_data_in = p1_a[16] ? ram[p1_a[15:0]] : 8'hEE;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  // ---------------- driver tasks ----------------
  task automatic cpu_idle();
    cpu_addr     = 16'h0000;
    cpu_data_out = 8'h00;
    cpu_write_en = 1'b0;
    cpu_read_en  = 1'b0;
  endtask

  task automatic l1_cpu_idle();
    l1_cpu_addr     = 16'h0000;
    l1_cpu_data_out = 8'h00;
    l1_cpu_write_en = 1'b0;
    l1_cpu_read_en  = 1'b0;
  endtask

  task automatic fill_ram();
    for (int a = 0; a < 65536; a++) ram[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
    for (int i = 0; i < 256; i++) begin
      ram[16'h0200 + i] = 8'(i) ^ 8'hA5;
      ram[16'hFF00 + i] = 8'(i) ^ 8'h5A;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    cpu_idle();
    l1_cpu_idle();
    #12;
    n_cmp++;
    if ({cpu_stall, dma_busy, dma_done, mem_write_en, mem_read_en, mem_addr, mem_data_out, fsm_state} !== 30'd0) begin
      n_mis++;
      $display("FAIL reset_outputs: got stall=%b busy=%b done=%b we=%b re=%b addr=%h data=%h st=%0d want all 0",
               cpu_stall, dma_busy, dma_done, mem_write_en, mem_read_en, mem_addr, mem_data_out, fsm_state);
    end
    cpu_addr = 16'h0300; cpu_read_en = 1'b1;
    #1;
    n_cmp++;
    if ({mem_read_en, mem_addr, cpu_stall} !== {1'b1, 16'h0300, 1'b0}) begin
      n_mis++;
      $display("FAIL reset_passthrough: got re=%b addr=%h stall=%b want re=1 addr=0300 stall=0",
               mem_read_en, mem_addr, cpu_stall);
    end
    cpu_idle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_passthrough();
    @(posedge clk); #1;
    cpu_addr = 16'h0300; cpu_read_en = 1'b1; cpu_write_en = 1'b0; cpu_data_out = 8'h00;
    @(negedge clk);
    n_cmp++;
    if ({cpu_stall, mem_read_en, mem_write_en, mem_addr} !== {1'b0, 1'b1, 1'b0, 16'h0300}) begin
      n_mis++;
      $display("FAIL pass_read: got stall=%b re=%b we=%b addr=%h want 0 1 0 0300",
               cpu_stall, mem_read_en, mem_write_en, mem_addr);
    end
    @(posedge clk); #1;
    cpu_addr = 16'h0200; cpu_data_out = 8'h55; cpu_write_en = 1'b1; cpu_read_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cpu_stall, mem_read_en, mem_write_en, mem_addr, mem_data_out} !== {1'b0, 1'b0, 1'b1, 16'h0200, 8'h55}) begin
      n_mis++;
      $display("FAIL pass_write: got stall=%b re=%b we=%b addr=%h data=%h want 0 0 1 0200 55",
               cpu_stall, mem_read_en, mem_write_en, mem_addr, mem_data_out);
    end
    @(posedge clk); #1;
    cpu_idle();
    @(negedge clk);
    n_cmp++;
    if ({cpu_stall, dma_busy} !== 2'b00) begin
      n_mis++;
      $display("FAIL pass_no_dma: got stall=%b busy=%b want 0 0", cpu_stall, dma_busy);
    end
  endtask

  task automatic test_no_trigger();
    @(posedge clk); #1;
    cpu_addr = 16'h4014; cpu_read_en = 1'b1; cpu_write_en = 1'b0;
    @(posedge clk); #1;
    cpu_addr = 16'h4015; cpu_data_out = 8'h02; cpu_write_en = 1'b1; cpu_read_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cpu_stall, mem_write_en, mem_addr, mem_data_out} !== {1'b0, 1'b1, 16'h4015, 8'h02}) begin
      n_mis++;
      $display("FAIL no_trig_write: got stall=%b we=%b addr=%h data=%h want 0 1 4015 02",
               cpu_stall, mem_write_en, mem_addr, mem_data_out);
    end
    @(posedge clk); #1;
    cpu_idle();
    @(negedge clk);
    n_cmp++;
    if ({cpu_stall, dma_busy, fsm_state} !== 5'd0) begin
      n_mis++;
      $display("FAIL no_trig_idle: got stall=%b busy=%b st=%0d want 0 0 0", cpu_stall, dma_busy, fsm_state);
    end
  endtask

  // Runs one DMA on the READ_LAT=2 instance. retrig_r: cycle (relative to the
  // trigger) carrying a write of $07 to $4014. abort_r: cycle at which rst is
  // pulled low; the caller releases it.
  task automatic do_dma(input logic [7:0] pg, input int retrig_r, input int abort_r);
    int rd_n, wr_n, done_r, stall_low, first_rd, first_wr;
    logic [7:0] exp_d;
    rd_n = 0; wr_n = 0; done_r = 0; stall_low = 0; first_rd = 0; first_wr = 0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(ram[{pg, 8'(i)}]);

    @(posedge clk); #1;
    cpu_addr = 16'h4014; cpu_data_out = pg; cpu_write_en = 1'b1; cpu_read_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cpu_stall, mem_write_en, mem_read_en, mem_addr, mem_data_out} !== {1'b0, 1'b1, 1'b0, 16'h4014, pg}) begin
      n_mis++;
      $display("FAIL trigger_pass: got stall=%b we=%b re=%b addr=%h data=%h want 0 1 0 4014 %h",
               cpu_stall, mem_write_en, mem_read_en, mem_addr, mem_data_out, pg);
    end

    for (int r = 1; r <= 1100 && done_r == 0; r++) begin
      @(posedge clk); #1;
      // A stalled CPU keeps issuing a read; it must never reach the bus.
      cpu_addr = 16'h0300; cpu_data_out = 8'h00; cpu_write_en = 1'b0; cpu_read_en = 1'b1;
      if (r == retrig_r) begin
        cpu_addr = 16'h4014; cpu_data_out = 8'h07; cpu_write_en = 1'b1; cpu_read_en = 1'b0;
      end
      if (r == abort_r) begin
        cpu_idle();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({cpu_stall, dma_busy, dma_done, mem_write_en, mem_read_en, mem_addr, mem_data_out, fsm_state} !== 30'd0) begin
          n_mis++;
          $display("FAIL abort_outputs: got stall=%b busy=%b done=%b we=%b re=%b addr=%h data=%h st=%0d want all 0",
                   cpu_stall, dma_busy, dma_done, mem_write_en, mem_read_en, mem_addr, mem_data_out, fsm_state);
        end
        return;
      end
      @(negedge clk);
      if (r == 1) begin
        n_cmp++;
        if ({cpu_stall, dma_busy, mem_read_en, mem_write_en, mem_addr} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
          n_mis++;
          $display("FAIL align: got stall=%b busy=%b re=%b we=%b addr=%h want 1 1 0 0 0000",
                   cpu_stall, dma_busy, mem_read_en, mem_write_en, mem_addr);
        end
      end
      if (!cpu_stall) stall_low++;
      if (mem_read_en) begin
        if (rd_n == 0) first_rd = r;
        n_cmp++;
        if (mem_addr !== {pg, 8'(rd_n)}) begin
          n_mis++;
          $display("FAIL dma_read[%0d]: got addr=%h want %h", rd_n, mem_addr, {pg, 8'(rd_n)});
        end
        rd_n++;
      end
      if (mem_write_en) begin
        if (wr_n == 0) first_wr = r;
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++;
        if ({mem_addr, mem_data_out} !== {16'h2004, exp_d}) begin
          n_mis++;
          $display("FAIL dma_write[%0d]: got addr=%h data=%h want addr=2004 data=%h",
                   wr_n, mem_addr, mem_data_out, exp_d);
        end
        wr_n++;
      end
      if (dma_done) begin
        done_r = r;
        n_cmp++;
        if ({cpu_stall, dma_busy, mem_read_en, mem_write_en} !== 4'b1000) begin
          n_mis++;
          $display("FAIL done_state: got stall=%b busy=%b re=%b we=%b want 1 0 0 0",
                   cpu_stall, dma_busy, mem_read_en, mem_write_en);
        end
      end
    end

    n_cmp++;
    if (first_rd != 2 || first_wr != 5) begin
      n_mis++;
      $display("FAIL first_byte_timing: got rd=T+%0d wr=T+%0d want rd=T+2 wr=T+5", first_rd, first_wr);
    end
    n_cmp++;
    if (done_r != 1026) begin
      n_mis++;
      $display("FAIL done_timing: got T+%0d want T+1026 (0 means never)", done_r);
    end
    n_cmp++;
    if (rd_n != 256 || wr_n != 256 || exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL byte_counts: got reads=%0d writes=%0d left=%0d want 256 256 0", rd_n, wr_n, exp_q.size());
    end
    n_cmp++;
    if (stall_low != 0) begin
      n_mis++;
      $display("FAIL stall_hold: got %0d cycles with stall low want 0", stall_low);
    end

    // T+1027: CPU owns the bus again.
    @(posedge clk); #1;
    cpu_addr = 16'h0200; cpu_data_out = 8'h55; cpu_write_en = 1'b1; cpu_read_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cpu_stall, dma_busy, dma_done, mem_write_en, mem_addr, mem_data_out} !== {3'b000, 1'b1, 16'h0200, 8'h55}) begin
      n_mis++;
      $display("FAIL release: got stall=%b busy=%b done=%b we=%b addr=%h data=%h want 0 0 0 1 0200 55",
               cpu_stall, dma_busy, dma_done, mem_write_en, mem_addr, mem_data_out);
    end
    @(posedge clk); #1;
    cpu_idle();
  endtask

  task automatic test_basic_dma();
    do_dma(8'h02, 0, 0);
  endtask

  task automatic test_page_wrap();
    do_dma(8'hFF, 0, 0);
  endtask

  task automatic test_retrigger();
    do_dma(8'h02, 100, 0);
  endtask

  task automatic test_reset_mid_dma();
    // Byte 37: RD at T+150, WAIT at T+151..152.
    do_dma(8'h02, 0, 151);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    cpu_addr = 16'h0210; cpu_data_out = 8'h3A; cpu_write_en = 1'b1; cpu_read_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cpu_stall, mem_write_en, mem_addr, mem_data_out} !== {1'b0, 1'b1, 16'h0210, 8'h3A}) begin
      n_mis++;
      $display("FAIL after_reset_pass: got stall=%b we=%b addr=%h data=%h want 0 1 0210 3A",
               cpu_stall, mem_write_en, mem_addr, mem_data_out);
    end
    @(posedge clk); #1;
    cpu_idle();
    do_dma(8'h02, 0, 0);
  endtask

  task automatic test_read_lat1();
    int wr_n, done_r, first_rd, first_wr, stall_low;
    logic [7:0] exp_d;
    wr_n = 0; done_r = 0; first_rd = 0; first_wr = 0; stall_low = 0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(ram[16'h0200 + i]);
    n_cmp++;
    if ({l1_cpu_stall, l1_dma_busy, l1_fsm_state} !== 5'd0) begin
      n_mis++;
      $display("FAIL l1_idle: got stall=%b busy=%b st=%0d want 0 0 0", l1_cpu_stall, l1_dma_busy, l1_fsm_state);
    end
    @(posedge clk); #1;
    l1_cpu_addr = 16'h4014; l1_cpu_data_out = 8'h02; l1_cpu_write_en = 1'b1;
    for (int r = 1; r <= 900 && done_r == 0; r++) begin
      @(posedge clk); #1;
      l1_cpu_idle();
      @(negedge clk);
      if (!l1_cpu_stall) stall_low++;
      if (l1_mem_read_en && first_rd == 0) first_rd = r;
      if (l1_mem_write_en) begin
        if (wr_n == 0) first_wr = r;
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++;
        if ({l1_mem_addr, l1_mem_data_out} !== {16'h2004, exp_d}) begin
          n_mis++;
          $display("FAIL l1_write[%0d]: got addr=%h data=%h want addr=2004 data=%h",
                   wr_n, l1_mem_addr, l1_mem_data_out, exp_d);
        end
        wr_n++;
      end
      if (l1_dma_done) done_r = r;
    end
    n_cmp++;
    if (first_rd != 2 || first_wr != 4) begin
      n_mis++;
      $display("FAIL l1_first_byte: got rd=T+%0d wr=T+%0d want rd=T+2 wr=T+4", first_rd, first_wr);
    end
    n_cmp++;
    if (done_r != 770 || wr_n != 256 || stall_low != 0) begin
      n_mis++;
      $display("FAIL l1_done: got done=T+%0d writes=%0d stall_low=%0d want T+770 256 0", done_r, wr_n, stall_low);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({l1_cpu_stall, l1_dma_busy} !== 2'b00) begin
      n_mis++;
      $display("FAIL l1_release: got stall=%b busy=%b want 0 0", l1_cpu_stall, l1_dma_busy);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    fill_ram();
    test_reset();
    test_passthrough();
    test_no_trigger();
    test_basic_dma();
    test_page_wrap();
    test_retrigger();
    test_reset_mid_dma();
    test_read_lat1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
